memory_responder: RTL
=====================

# memory_responder

Bus-side memory responder for the asynchronous-strobe memory interface (as_n / wr_n / ack_n). It sits opposite the write/read initiator state machine. It accepts one request per address-strobe assertion, inserts a fixed number of wait states, then performs the access on its internal word memory. It acknowledges each completed access with a single-cycle ack_n pulse.

## Interface
Parameters:
- ADDR_W, 8: address width in bits.
- DATA_W, 32: data word width in bits.
- DEPTH, 256: number of implemented words; must be ≤ 2**ADDR_W.
- WAIT_CYCLES, 2: wait states inserted before the access; range 0..15.

Ports:
- clk  in  1  single clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- as_n  in  1  address strobe, active low; held low by the initiator until it sees ack_n.
- wr_n  in  1  access type, sampled with as_n; 0 = write, 1 = read.
- addr  in  ADDR_W  word address, sampled with as_n.
- wdata  in  DATA_W  write data, sampled with as_n.
- rdata  out  DATA_W  read data; valid in the cycle ack_n is low.
- ack_n  out  1  acknowledge, active low, one-cycle pulse.
- busy  out  1  high from request capture until the acknowledge cycle ends.
- err  out  1  sticky flag: an access targeted addr ≥ DEPTH.
- rsp_state  out  2  current state, for debug.

## Operation
- States: IDLE=0, WAIT=1, ACK=2, RELEASE=3.
- IDLE:
  - If as_n is sampled 0: capture addr, wr_n and wdata; load cnt ← WAIT_CYCLES; busy ← 1; go to WAIT.
  - Otherwise stay in IDLE.
- WAIT:
  - If as_n is sampled 1, the request is aborted: go to IDLE, busy ← 0, no memory access, no ack.
  - Else, if cnt ≠ 0: cnt ← cnt − 1.
  - Else (cnt = 0), perform the access:
    - Write: mem[addr] ← wdata.
    - Read: rdata ← mem[addr].
    - Then ack_n ← 0 and go to ACK.
- ACK:
  - ack_n ← 1, busy ← 0.
  - If as_n is sampled 1, go to IDLE; else go to RELEASE.
- RELEASE: wait for as_n to be sampled 1, then go to IDLE. No new request is accepted while as_n stays low, so one strobe produces exactly one access.
- Out-of-range address (addr ≥ DEPTH):
  - Write is dropped.
  - Read returns rdata = 0.
  - ack_n is still pulsed and err ← 1.
  - err clears only on reset.
- rdata holds its last value until the next read completes. Writes do not change rdata.
- Only the values captured in IDLE are used. Changes on addr, wr_n or wdata during WAIT are ignored.

## Timing
- Reset (asynchronous, immediate on reset_n falling):
  - rsp_state = IDLE, ack_n = 1, busy = 0, err = 0, rdata = 0, cnt = 0.
  - Memory contents are not cleared.
- Reset asserted mid-transaction abandons the transaction. If the reset lands in WAIT, no write occurs.
- Latency:
  - Edge N samples as_n = 0.
  - Memory update or rdata load, and ack_n falling, both happen at edge N+1+WAIT_CYCLES.
  - ack_n rises at the following edge.
  - WAIT_CYCLES = 0 gives ack_n low in the cycle after N+1.
- An initiator that releases as_n on the edge where it samples ack_n = 0 goes RELEASE-free: ACK → IDLE.
- Back-to-back throughput: one access per WAIT_CYCLES+3 cycles minimum (includes one IDLE cycle with as_n high).
- Abort window: as_n rising before the access edge cancels the access. as_n rising on the access edge itself does not cancel it, because the access uses the sample taken at that edge.

## Structure
- Shared package memory_bus_pkg holds:
  - state encodings IDLE/WAIT/ACK/RELEASE;
  - the wr_n encoding constants (BUS_WRITE = 0, BUS_READ = 1).
- The initiator imports the same package.
- Sub-module responder_mem: single-port synchronous word memory (DEPTH × DATA_W) with write enable and registered read. The FSM, wait counter, range check and err live in memory_responder.

## Test plan
- Write then read, WAIT_CYCLES = 2:
  - Write addr 0x10, wdata 0xDEADBEEF → ack_n low exactly 3 cycles after the as_n sample, for one cycle.
  - Read of 0x10 → rdata = 0xDEADBEEF during its ack cycle.
- WAIT_CYCLES = 0: read addr 0x00 after writing 0x00000005 → ack_n low at edge N+1, rdata = 5; busy high for exactly 2 cycles.
- Abort: as_n low for 1 cycle, then high, with wr_n = 0, addr 0x20, wdata 0x1234 → no ack_n pulse, state returns to IDLE. A later read of 0x20 returns its prior value.
- Long strobe: initiator holds as_n low for 6 cycles after ack → exactly one ack_n pulse, rsp_state = RELEASE until as_n rises, single write performed.
- Out of range, DEPTH = 200: write addr 250 → ack_n pulses, err = 1. Read addr 250 → rdata = 0. Read addr 199 is unaffected.
- Reset mid-WAIT: reset_n low during WAIT of a write to 0x30 → ack_n = 1, busy = 0, rsp_state = IDLE immediately. A later read of 0x30 returns the old value and err = 0.

Source files
------------

// File: rtl/memory_bus_pkg.sv
// rtl/memory_bus_pkg.sv - shared state and bus encodings for the strobe memory bus
package memory_bus_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } rsp_state_t;

  localparam logic BUS_WRITE = 1'b0;
  localparam logic BUS_READ  = 1'b1;

  localparam int CNT_W = 4;

endpackage

// File: rtl/memory_responder_if.sv
// rtl/memory_responder_if.sv - as_n/wr_n/ack_n strobe bus between initiator and responder
interface memory_responder_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);

  logic              as_n;
  logic              wr_n;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack_n;

  modport master (
    output as_n, wr_n, addr, wdata,
    input  rdata, ack_n
  );

  modport slave (
    input  as_n, wr_n, addr, wdata,
    output rdata, ack_n
  );

endinterface

// File: rtl/responder_mem.sv
// rtl/responder_mem.sv - single-port word memory with write enable and registered read
module responder_mem #(
  parameter int DEPTH  = 256,
  parameter int DATA_W = 32,
  parameter int IDX_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              en,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] mem [DEPTH];

  // The array itself is never reset; only the read register is.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else if (en && !we) begin
      q <= mem[idx];
    end
  end

endmodule

// File: rtl/memory_responder.sv
// rtl/memory_responder.sv - strobe-bus responder: capture, wait states, access, one-cycle ack
module memory_responder
  import memory_bus_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  memory_responder_if.slave  bus,
  output logic               busy,
  output logic               err,
  output logic [1:0]         rsp_state
);

  localparam int               IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_CYCLES);

  rsp_state_t        state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ADDR_W-1:0] cap_addr;
  logic              cap_wr_n;
  logic [DATA_W-1:0] cap_wdata;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q;
  logic              oor_rd;
  logic              capture;
  logic              access;
  logic              in_range;
  logic [DATA_W-1:0] mem_q;

  assign in_range = {1'b0, cap_addr} < DEPTH_L;

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    ack_d   = 1'b1;
    busy_d  = busy_q;
    capture = 1'b0;
    access  = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.as_n) begin
          capture = 1'b1;
          cnt_d   = WAIT_L;
          busy_d  = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // A strobe released before the access edge cancels the request.
        if (bus.as_n) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          access  = 1'b1;
          ack_d   = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        busy_d  = 1'b0;
        state_d = bus.as_n ? IDLE : RELEASE;
      end
      RELEASE: begin
        if (bus.as_n) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      ack_q     <= 1'b1;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      oor_rd    <= 1'b0;
      cap_addr  <= '0;
      cap_wr_n  <= BUS_READ;
      cap_wdata <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      ack_q  <= ack_d;
      busy_q <= busy_d;
      if (capture) begin
        cap_addr  <= bus.addr;
        cap_wr_n  <= bus.wr_n;
        cap_wdata <= bus.wdata;
      end
      if (access && !in_range) begin
        err_q <= 1'b1;
      end
      // Out-of-range reads present zero without disturbing the memory read register.
      if (access && cap_wr_n == BUS_READ) begin
        oor_rd <= !in_range;
      end
    end
  end

  responder_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (access && in_range),
    .we      (cap_wr_n == BUS_WRITE),
    .idx     (cap_addr[IDX_W-1:0]),
    .wdata   (cap_wdata),
    .q       (mem_q)
  );

  assign bus.ack_n = ack_q;
  assign bus.rdata = oor_rd ? '0 : mem_q;
  assign busy      = busy_q;
  assign err       = err_q;
  assign rsp_state = state;

endmodule
